// File: rtl/range_frame_sequencer.sv
// range_frame_sequencer: frames a valid/ready sample stream into one range-finder
// measurement (data_out/go/finish) and holds the returned range until acked.
// Latency: finder outputs are registered, 1 cycle after sample acceptance.
// Backpressure: sample_ready is high in ARMED/RUN only and depends on state alone.
//
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   sample_in/_valid/_ready  input sample stream (valid/ready)
//   start, frame_len       begin a frame of frame_len samples (sampled in IDLE)
//   abort                  terminate the current frame, result discarded
//   data_out, go, finish   drive the range finder's data_in/go/finish
//   range_in, error_in     range finder outputs, captured during finish
//   result, result_err, result_valid, result_ack  held result with ack handshake
//   busy, cfg_err, aborted, timeout  status and one-cycle event pulses
//
// Build option: define RFS_TIMEOUT_EN to add an idle watchdog in RUN that forces
// a finish after TIMEOUT_CYC cycles without an accepted sample.
module range_frame_sequencer #(
  parameter int WIDTH       = 8,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             go,
  output logic             finish,
  input  logic [WIDTH-1:0] range_in,
  input  logic             error_in,
  output logic [WIDTH-1:0] result,
  output logic             result_err,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic             cfg_err,
  output logic             aborted,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, TERM} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] count, count_n;
  // cap_q travels with finish: it says whether the finish now on the wire
  // ends a frame whose range should be kept (clear for aborted frames).
  logic             cap_q, cap_n;
  // ferr_q marks a watchdog-forced finish; its captured error is forced to 1.
  logic             ferr_q, ferr_n;
  logic             ld_data, go_n, fin_n, cfg_n, abt_n, to_n;
  logic             accept, last, to_hit;

  assign sample_ready = (state == ARMED) || (state == RUN);
  assign busy         = (state != IDLE);
  assign accept       = sample_valid && sample_ready;
  assign last         = (state == RUN) && accept && (count == len_q - LEN_ONE);

`ifdef RFS_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive RUN cycle without an accept.
  assign to_hit = (state == RUN) && !accept &&
                  (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state != RUN) || accept || to_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  // No watchdog: RUN waits for samples indefinitely. The limit is inert here
  // and a negative limit is meaningless, so this is constant 0.
  assign to_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_n = state;
    len_n   = len_q;
    count_n = count;
    ld_data = 1'b0;
    go_n    = 1'b0;
    fin_n   = 1'b0;
    cap_n   = 1'b0;
    ferr_n  = 1'b0;
    cfg_n   = 1'b0;
    abt_n   = 1'b0;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          // A 1-sample frame would need go and finish in the same cycle.
          if (frame_len < LEN_MIN) begin
            cfg_n = 1'b1;
          end else begin
            len_n   = frame_len;
            count_n = '0;
            state_n = ARMED;
          end
        end
      end
      ARMED: begin
        if (abort) begin
          abt_n   = 1'b1;
          state_n = IDLE;
        end else if (accept) begin
          ld_data = 1'b1;
          go_n    = 1'b1;
          count_n = LEN_ONE;
          state_n = RUN;
        end
      end
      RUN: begin
        // Last-sample acceptance beats a simultaneous abort.
        if (last) begin
          ld_data = 1'b1;
          fin_n   = 1'b1;
          cap_n   = 1'b1;
          state_n = IDLE;
        end else if (abort) begin
          // Close the finder with a finish on the held data rather than
          // letting the next frame's go arrive mid-measurement.
          fin_n   = 1'b1;
          abt_n   = 1'b1;
          state_n = TERM;
        end else if (accept) begin
          ld_data = 1'b1;
          count_n = count + LEN_ONE;
        end else if (to_hit) begin
          fin_n   = 1'b1;
          cap_n   = 1'b1;
          ferr_n  = 1'b1;
          to_n    = 1'b1;
          state_n = TERM;
        end
      end
      TERM: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      count        <= '0;
      data_out     <= '0;
      go           <= 1'b0;
      finish       <= 1'b0;
      cap_q        <= 1'b0;
      ferr_q       <= 1'b0;
      cfg_err      <= 1'b0;
      aborted      <= 1'b0;
      timeout      <= 1'b0;
      result       <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state   <= state_n;
      len_q   <= len_n;
      count   <= count_n;
      go      <= go_n;
      finish  <= fin_n;
      cap_q   <= cap_n;
      ferr_q  <= ferr_n;
      cfg_err <= cfg_n;
      aborted <= abt_n;
      timeout <= to_n;
      // Without a load, data_out keeps its last sample; a repeat is harmless
      // to the finder's min/max tracking.
      if (ld_data) begin
        data_out <= sample_in;
      end
      // A capture overwrites any unacked result and wins over a same-cycle ack.
      if (finish && cap_q) begin
        result       <= range_in;
        result_err   <= error_in | ferr_q;
        result_valid <= 1'b1;
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_range_frame_sequencer.sv
module tb_range_frame_sequencer;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] sample_in = '0;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] range_in = '0;
  logic             error_in = 1'b0;
  logic [WIDTH-1:0] result;
  logic             result_err;
  logic             result_valid;
  logic             result_ack = 1'b0;
  logic             busy;
  logic             cfg_err;
  logic             aborted;
  logic             timeout;

  int n_chk  = 0;
  int n_pass = 0;

  range_frame_sequencer #(
    .WIDTH       (WIDTH),
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .start        (start),
    .frame_len    (frame_len),
    .abort        (abort),
    .data_out     (data_out),
    .go           (go),
    .finish       (finish),
    .range_in     (range_in),
    .error_in     (error_in),
    .result       (result),
    .result_err   (result_err),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .aborted      (aborted),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_frame(input int len);
    frame_len = LEN_W'(len);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  initial begin
    bit seen_fin;

    // ---------------- reset state ----------------
    #12;
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_go", 32'(go), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_result_err", 32'(result_err), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(sample_ready), 0);
    reset = 1'b0;
    step();

    // ---------------- len 4: 10,3,25,7 back to back ----------------
    range_in = 8'd22;
    begin_frame(4);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_ready", 32'(sample_ready), 1);
    chk("t2_go_before", 32'(go), 0);
    sample_valid = 1'b1;
    sample_in = 8'd10; step();
    chk("t2_go", 32'(go), 1);
    chk("t2_d0", 32'(data_out), 10);
    chk("t2_fin0", 32'(finish), 0);
    sample_in = 8'd3; step();
    chk("t2_go_low", 32'(go), 0);
    chk("t2_d1", 32'(data_out), 3);
    sample_in = 8'd25; step();
    chk("t2_d2", 32'(data_out), 25);
    chk("t2_fin2", 32'(finish), 0);
    sample_in = 8'd7; step();
    sample_valid = 1'b0;
    chk("t2_fin", 32'(finish), 1);
    chk("t2_go_at_fin", 32'(go), 0);
    chk("t2_d3", 32'(data_out), 7);
    chk("t2_busy_end", 32'(busy), 0);
    chk("t2_rv_before", 32'(result_valid), 0);
    step();
    chk("t2_fin_off", 32'(finish), 0);
    chk("t2_result", 32'(result), 22);
    chk("t2_result_err", 32'(result_err), 0);
    chk("t2_rv", 32'(result_valid), 1);
    range_in = 8'd77;
    step();
    chk("t2_rv_hold", 32'(result_valid), 1);
    chk("t2_result_hold", 32'(result), 22);
    result_ack = 1'b1; step(); result_ack = 1'b0;
    chk("t2_rv_acked", 32'(result_valid), 0);

    // ---------------- reset mid-frame ----------------
    // Leave a held result so the reset has something to clear.
    range_in = 8'd40;
    begin_frame(2);
    sample_valid = 1'b1;
    sample_in = 8'd1; step();
    sample_in = 8'd2; step();
    sample_valid = 1'b0;
    step();
    chk("t1_rv_pre", 32'(result_valid), 1);
    begin_frame(4);
    sample_valid = 1'b1;
    sample_in = 8'd10; step();
    sample_valid = 1'b0;
    chk("t1_go", 32'(go), 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_go_rst", 32'(go), 0);
    chk("t1_data_rst", 32'(data_out), 0);
    chk("t1_busy_rst", 32'(busy), 0);
    chk("t1_rv_rst", 32'(result_valid), 0);
    chk("t1_result_rst", 32'(result), 0);
    #2 reset = 1'b0;
    step();
    chk("t1_busy_after", 32'(busy), 0);

    // ---------------- bad frame lengths ----------------
    begin_frame(1);
    chk("t3_cfg1", 32'(cfg_err), 1);
    chk("t3_busy1", 32'(busy), 0);
    step();
    chk("t3_cfg_pulse", 32'(cfg_err), 0);
    begin_frame(0);
    chk("t3_cfg0", 32'(cfg_err), 1);
    chk("t3_busy0", 32'(busy), 0);
    chk("t3_go", 32'(go), 0);
    chk("t3_fin", 32'(finish), 0);
    step();

    // ---------------- abort in ARMED ----------------
    begin_frame(3);
    abort = 1'b1; step(); abort = 1'b0;
    chk("ta_aborted", 32'(aborted), 1);
    chk("ta_busy", 32'(busy), 0);
    chk("ta_fin", 32'(finish), 0);
    step();
    chk("ta_go", 32'(go), 0);

    // ---------------- abort in RUN ----------------
    range_in = 8'd55;
    begin_frame(6);
    sample_valid = 1'b1;
    sample_in = 8'd5; step();
    sample_in = 8'd9; step();
    sample_valid = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_fin", 32'(finish), 1);
    chk("t4_data", 32'(data_out), 9);
    chk("t4_aborted", 32'(aborted), 1);
    chk("t4_go", 32'(go), 0);
    step();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_rv", 32'(result_valid), 0);
    chk("t4_fin_off", 32'(finish), 0);
    chk("t4_abort_pulse", 32'(aborted), 0);

    // ---------------- abort with last sample: acceptance wins ----------------
    range_in = 8'd99;
    begin_frame(2);
    sample_valid = 1'b1;
    sample_in = 8'd11; step();
    sample_in = 8'd12; abort = 1'b1; step();
    sample_valid = 1'b0; abort = 1'b0;
    chk("tl_fin", 32'(finish), 1);
    chk("tl_data", 32'(data_out), 12);
    chk("tl_aborted", 32'(aborted), 0);
    step();
    chk("tl_result", 32'(result), 99);
    chk("tl_rv", 32'(result_valid), 1);

    // ---------------- len 3 with gap; capture + ack same cycle ----------------
    range_in = 8'd6;
    begin_frame(3);
    sample_valid = 1'b1;
    sample_in = 8'd4; step();
    sample_valid = 1'b0;
    sample_in = 8'd200;
    chk("t5_go", 32'(go), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_gap_data", 32'(data_out), 4);
      chk("t5_gap_go", 32'(go), 0);
      chk("t5_gap_fin", 32'(finish), 0);
    end
    sample_valid = 1'b1;
    sample_in = 8'd8; step();
    chk("t5_d1", 32'(data_out), 8);
    sample_in = 8'd2; step();
    sample_valid = 1'b0;
    chk("t5_fin", 32'(finish), 1);
    chk("t5_d2", 32'(data_out), 2);
    result_ack = 1'b1; step(); result_ack = 1'b0;
    chk("t5_result", 32'(result), 6);
    chk("t5_rv_overwrite", 32'(result_valid), 1);
    result_ack = 1'b1; step(); result_ack = 1'b0;
    chk("t5_rv_acked", 32'(result_valid), 0);

`ifdef RFS_TIMEOUT_EN
    // ---------------- idle timeout ----------------
    range_in = 8'd1;
    begin_frame(5);
    sample_valid = 1'b1;
    sample_in = 8'd1; step();
    sample_in = 8'd2; step();
    sample_valid = 1'b0;
    seen_fin = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (finish) seen_fin = 1'b1;
    end
    chk("t6_no_early_fin", 32'(seen_fin), 0);
    step();
    chk("t6_fin", 32'(finish), 1);
    chk("t6_timeout", 32'(timeout), 1);
    chk("t6_data", 32'(data_out), 2);
    step();
    chk("t6_result", 32'(result), 1);
    chk("t6_result_err", 32'(result_err), 1);
    chk("t6_rv", 32'(result_valid), 1);
    chk("t6_busy", 32'(busy), 0);
    result_ack = 1'b1; step(); result_ack = 1'b0;
`else
    // ---------------- no watchdog: RUN waits ----------------
    begin_frame(3);
    sample_valid = 1'b1;
    sample_in = 8'd1; step();
    sample_valid = 1'b0;
    seen_fin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (finish || timeout) seen_fin = 1'b1;
    end
    chk("tn_no_fin", 32'(seen_fin), 0);
    chk("tn_busy", 32'(busy), 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("tn_abort_fin", 32'(finish), 1);
    step();
    chk("tn_idle", 32'(busy), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
